// File: rtl/core_ahb_arbiter_pkg.sv
// rtl/core_ahb_arbiter_pkg.sv - shared AHB-Lite encodings and arbiter select type
package core_ahb_arbiter_pkg;

  localparam logic [1:0] AHB_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_HTRANS_SEQ    = 2'b11;

  localparam logic AHB_HRESP_OKAY  = 1'b0;
  localparam logic AHB_HRESP_ERROR = 1'b1;

  typedef enum logic {
    ARB_SEL_M0 = 1'b0,
    ARB_SEL_M1 = 1'b1
  } arb_sel_e;

  // SEQ is handled exactly like NONSEQ; BUSY like IDLE
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == AHB_HTRANS_NONSEQ) || (htrans == AHB_HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/core_ahb_arbiter_if.sv
// rtl/core_ahb_arbiter_if.sv - AHB-Lite port bundle shared by master and slave sides
interface core_ahb_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic              hmastlock;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic              hmaster;

  modport master (
    output htrans, haddr, hwrite, hsize, hburst, hmastlock, hwdata, hmaster,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  htrans, haddr, hwrite, hsize, hburst, hmastlock, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/core_ahb_arb_input_stage.sv
// rtl/core_ahb_arb_input_stage.sv - per-master holding register, pending/data-phase flags,
// and hready/hresp back to the master
module core_ahb_arb_input_stage
  import core_ahb_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic              hmastlock,
  input  logic              grant,
  input  logic              s_hready,
  input  logic              s_hresp,
  output logic              hready,
  output logic              hresp,
  output logic              live,
  output logic              pend_vld,
  output logic              dph_vld,
  output logic [ADDR_W-1:0] req_addr,
  output logic              req_write,
  output logic [2:0]        req_size,
  output logic [2:0]        req_burst,
  output logic              req_lock
);

  logic [ADDR_W-1:0] hold_addr;
  logic              hold_write;
  logic [2:0]        hold_size;
  logic [2:0]        hold_burst;
  logic              hold_lock;

  always_comb begin
    hready = dph_vld ? s_hready : !pend_vld;
    hresp  = dph_vld ? s_hresp : AHB_HRESP_OKAY;
    live   = htrans_active(htrans) && hready;
  end

  // A held request never coexists with a live one: hready is low while pending
  always_comb begin
    req_addr  = pend_vld ? hold_addr  : haddr;
    req_write = pend_vld ? hold_write : hwrite;
    req_size  = pend_vld ? hold_size  : hsize;
    req_burst = pend_vld ? hold_burst : hburst;
    req_lock  = pend_vld ? hold_lock  : hmastlock;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_vld   <= 1'b0;
      dph_vld    <= 1'b0;
      hold_addr  <= '0;
      hold_write <= 1'b0;
      hold_size  <= 3'd0;
      hold_burst <= 3'd0;
      hold_lock  <= 1'b0;
    end else begin
      if (grant) begin
        pend_vld <= 1'b0;
      end else if (live) begin
        pend_vld   <= 1'b1;
        hold_addr  <= haddr;
        hold_write <= hwrite;
        hold_size  <= hsize;
        hold_burst <= hburst;
        hold_lock  <= hmastlock;
      end
      // Grants only happen on s_hready, which also retires the previous data phase
      if (s_hready) begin
        dph_vld <= grant;
      end
    end
  end

endmodule

// File: rtl/core_ahb_arbiter.sv
// rtl/core_ahb_arbiter.sv - two-master to one-slave AHB-Lite arbiter; define
// CORE_AHB_ARB_RR_EN for round-robin ties, otherwise M1 wins ties
module core_ahb_arbiter
  import core_ahb_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  core_ahb_arbiter_if.slave  m0,
  core_ahb_arbiter_if.slave  m1,
  core_ahb_arbiter_if.master s
);

  logic              live0, live1, pend0, pend1, dph0, dph1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              write0, write1, lock0, lock1;
  logic [2:0]        size0, size1, burst0, burst1;
  logic              req0, req1, grant0, grant1, gnt_any, tie_m1, owner_req;
  logic              lock_vld;
  arb_sel_e          data_owner, lock_owner;
  logic [DATA_W-1:0] wdata_sel;
`ifdef CORE_AHB_ARB_RR_EN
  arb_sel_e          last_grant;
`endif

  core_ahb_arb_input_stage #(.ADDR_W(ADDR_W)) u_in0 (
    .clk(clk), .rstn(rstn),
    .htrans(m0.htrans), .haddr(m0.haddr), .hwrite(m0.hwrite), .hsize(m0.hsize),
    .hburst(m0.hburst), .hmastlock(m0.hmastlock),
    .grant(grant0), .s_hready(s.hready), .s_hresp(s.hresp),
    .hready(m0.hready), .hresp(m0.hresp), .live(live0), .pend_vld(pend0), .dph_vld(dph0),
    .req_addr(addr0), .req_write(write0), .req_size(size0), .req_burst(burst0), .req_lock(lock0)
  );

  core_ahb_arb_input_stage #(.ADDR_W(ADDR_W)) u_in1 (
    .clk(clk), .rstn(rstn),
    .htrans(m1.htrans), .haddr(m1.haddr), .hwrite(m1.hwrite), .hsize(m1.hsize),
    .hburst(m1.hburst), .hmastlock(m1.hmastlock),
    .grant(grant1), .s_hready(s.hready), .s_hresp(s.hresp),
    .hready(m1.hready), .hresp(m1.hresp), .live(live1), .pend_vld(pend1), .dph_vld(dph1),
    .req_addr(addr1), .req_write(write1), .req_size(size1), .req_burst(burst1), .req_lock(lock1)
  );

  always_comb begin
    req0      = live0 | pend0;
    req1      = live1 | pend1;
    owner_req = (lock_owner == ARB_SEL_M1) ? req1 : req0;
`ifdef CORE_AHB_ARB_RR_EN
    tie_m1    = (last_grant == ARB_SEL_M0);
`else
    tie_m1    = 1'b1;
`endif
    grant0 = 1'b0;
    grant1 = 1'b0;
    // rstn gates the grant so a live request cannot leak through during reset
    if (rstn && s.hready) begin
      if (lock_vld) begin
        grant0 = (lock_owner == ARB_SEL_M0) && req0;
        grant1 = (lock_owner == ARB_SEL_M1) && req1;
      end else if (pend0 != pend1) begin
        grant0 = pend0;
        grant1 = pend1;
      end else if (req0 && req1) begin
        grant0 = !tie_m1;
        grant1 = tie_m1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
    gnt_any = grant0 | grant1;
  end

  always_comb begin
    s.htrans    = AHB_HTRANS_IDLE;
    s.haddr     = '0;
    s.hwrite    = 1'b0;
    s.hsize     = 3'd0;
    s.hburst    = 3'd0;
    s.hmastlock = 1'b0;
    s.hmaster   = data_owner;
    if (gnt_any) begin
      s.htrans    = AHB_HTRANS_NONSEQ;
      s.hmaster   = grant1;
      s.haddr     = grant1 ? addr1  : addr0;
      s.hwrite    = grant1 ? write1 : write0;
      s.hsize     = grant1 ? size1  : size0;
      s.hburst    = grant1 ? burst1 : burst0;
      s.hmastlock = grant1 ? lock1  : lock0;
    end
  end

  assign wdata_sel = (dph0 | dph1) ? ((data_owner == ARB_SEL_M1) ? m1.hwdata : m0.hwdata) : '0;
  assign s.hwdata  = wdata_sel;
  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;

  // Lock drops on the owner's next unlocked grant or on a slot where it has no request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_owner <= ARB_SEL_M0;
      lock_owner <= ARB_SEL_M0;
      lock_vld   <= 1'b0;
    end else if (gnt_any) begin
      data_owner <= arb_sel_e'(grant1);
      lock_owner <= arb_sel_e'(grant1);
      lock_vld   <= grant1 ? lock1 : lock0;
    end else if (lock_vld && s.hready && !owner_req) begin
      lock_vld <= 1'b0;
    end
  end

`ifdef CORE_AHB_ARB_RR_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= ARB_SEL_M1;
    end else if (gnt_any) begin
      last_grant <= arb_sel_e'(grant1);
    end
  end
`endif

endmodule

// File: tb/tb_core_ahb_arbiter.sv
// tb/tb_core_ahb_arbiter.sv - directed self-checking bench for core_ahb_arbiter
module tb_core_ahb_arbiter;
  import core_ahb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef CORE_AHB_ARB_RR_EN
  localparam logic FIRST_TIE = 1'b0;
`else
  localparam logic FIRST_TIE = 1'b1;
`endif

  core_ahb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  core_ahb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  core_ahb_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  core_ahb_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .m0(m0_if), .m1(m1_if), .s(s_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_drive(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    m0_if.htrans = t; m0_if.haddr = a; m0_if.hwrite = w; m0_if.hmastlock = l;
  endtask

  task automatic m1_drive(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    m1_if.htrans = t; m1_if.haddr = a; m1_if.hwrite = w; m1_if.hmastlock = l;
  endtask

  task automatic bus_idle();
    m0_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    m1_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    s_if.hready = 1'b1;
    s_if.hresp  = AHB_HRESP_OKAY;
  endtask

  task automatic test_reset();
    m0_if.hsize = 3'd2; m1_if.hsize = 3'd2; m0_if.hburst = 3'd0; m1_if.hburst = 3'd0;
    m0_if.hwdata = 32'h0; m1_if.hwdata = 32'h0; m0_if.hmaster = 1'b0; m1_if.hmaster = 1'b0;
    s_if.hrdata = 32'h0;
    bus_idle();
    m0_drive(AHB_HTRANS_NONSEQ, 32'h55, 1'b1, 1'b0);
    step(); step();
    checks++; if (s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL reset_htrans: got %0h expected 0", s_if.htrans); end
    checks++; if (s_if.haddr !== 32'h0) begin errors++; $display("FAIL reset_haddr: got %0h expected 0", s_if.haddr); end
    checks++; if (s_if.hmaster !== 1'b0) begin errors++; $display("FAIL reset_hmaster: got %0b expected 0", s_if.hmaster); end
    checks++; if ({m0_if.hready, m1_if.hready} !== 2'b11) begin errors++; $display("FAIL reset_hready: got %b expected 11", {m0_if.hready, m1_if.hready}); end
    checks++; if ({m0_if.hresp, m1_if.hresp} !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b expected 00", {m0_if.hresp, m1_if.hresp}); end
    checks++; if (s_if.hwdata !== 32'h0) begin errors++; $display("FAIL reset_hwdata: got %0h expected 0", s_if.hwdata); end
    bus_idle();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_single();
    step();
    m0_drive(AHB_HTRANS_NONSEQ, 32'h100, 1'b0, 1'b0);
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_NONSEQ) begin errors++; $display("FAIL single_htrans: got %0h expected 2", s_if.htrans); end
    checks++; if (s_if.haddr !== 32'h100) begin errors++; $display("FAIL single_haddr: got %0h expected 100", s_if.haddr); end
    checks++; if (s_if.hmaster !== 1'b0) begin errors++; $display("FAIL single_hmaster: got %0b expected 0", s_if.hmaster); end
    checks++; if (s_if.hsize !== 3'd2) begin errors++; $display("FAIL single_hsize: got %0d expected 2", s_if.hsize); end
    checks++; if (m0_if.hready !== 1'b1) begin errors++; $display("FAIL single_addr_hready: got %0b expected 1", m0_if.hready); end
    step();
    m0_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    s_if.hrdata = 32'hCAFE0001;
    #2;
    checks++; if (m0_if.hrdata !== 32'hCAFE0001) begin errors++; $display("FAIL single_hrdata: got %0h expected cafe0001", m0_if.hrdata); end
    checks++; if (m0_if.hready !== 1'b1) begin errors++; $display("FAIL single_data_hready: got %0b expected 1", m0_if.hready); end
    checks++; if (s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL single_after_htrans: got %0h expected 0", s_if.htrans); end
    checks++; if (s_if.hmaster !== 1'b0) begin errors++; $display("FAIL single_hmaster_hold: got %0b expected 0", s_if.hmaster); end
    bus_idle();
  endtask

  task automatic test_contention();
    step();
    m0_drive(AHB_HTRANS_NONSEQ, 32'h200, 1'b0, 1'b0);
    m1_drive(AHB_HTRANS_NONSEQ, 32'h300, 1'b1, 1'b0);
    #2;
    checks++; if (s_if.hmaster !== 1'b1) begin errors++; $display("FAIL cont_c0_hmaster: got %0b expected 1", s_if.hmaster); end
    checks++; if (s_if.haddr !== 32'h300) begin errors++; $display("FAIL cont_c0_haddr: got %0h expected 300", s_if.haddr); end
    checks++; if (s_if.hwrite !== 1'b1) begin errors++; $display("FAIL cont_c0_hwrite: got %0b expected 1", s_if.hwrite); end
    step();
    bus_idle();
    m1_if.hwdata = 32'hD1;
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_NONSEQ) begin errors++; $display("FAIL cont_c1_htrans: got %0h expected 2", s_if.htrans); end
    checks++; if (s_if.haddr !== 32'h200) begin errors++; $display("FAIL cont_c1_haddr: got %0h expected 200", s_if.haddr); end
    checks++; if (s_if.hmaster !== 1'b0) begin errors++; $display("FAIL cont_c1_hmaster: got %0b expected 0", s_if.hmaster); end
    checks++; if (m0_if.hready !== 1'b0) begin errors++; $display("FAIL cont_c1_m0_hready: got %0b expected 0", m0_if.hready); end
    checks++; if (s_if.hwdata !== 32'hD1) begin errors++; $display("FAIL cont_c1_hwdata: got %0h expected d1", s_if.hwdata); end
    step();
    m0_if.hwdata = 32'h77;
    #2;
    checks++; if (m0_if.hready !== 1'b1) begin errors++; $display("FAIL cont_c2_m0_hready: got %0b expected 1", m0_if.hready); end
    checks++; if (s_if.hwdata !== 32'h77) begin errors++; $display("FAIL cont_c2_hwdata: got %0h expected 77", s_if.hwdata); end
    checks++; if (s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL cont_c2_htrans: got %0h expected 0", s_if.htrans); end
    m0_if.hwdata = 32'h0; m1_if.hwdata = 32'h0;
  endtask

  task automatic test_lock();
    step();
    bus_idle();
    m1_drive(AHB_HTRANS_NONSEQ, 32'h400, 1'b1, 1'b1);
    #2;
    checks++; if ({s_if.hmaster, s_if.hmastlock} !== 2'b11) begin errors++; $display("FAIL lock_c0_owner_lock: got %b expected 11", {s_if.hmaster, s_if.hmastlock}); end
    step();
    m1_drive(AHB_HTRANS_NONSEQ, 32'h404, 1'b0, 1'b1);
    m0_drive(AHB_HTRANS_NONSEQ, 32'h500, 1'b0, 1'b0);
    #2;
    checks++; if (s_if.hmaster !== 1'b1) begin errors++; $display("FAIL lock_c1_hmaster: got %0b expected 1", s_if.hmaster); end
    checks++; if (s_if.haddr !== 32'h404) begin errors++; $display("FAIL lock_c1_haddr: got %0h expected 404", s_if.haddr); end
    step();
    m1_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    m0_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL lock_c2_htrans: got %0h expected 0", s_if.htrans); end
    checks++; if (m0_if.hready !== 1'b0) begin errors++; $display("FAIL lock_c2_m0_hready: got %0b expected 0", m0_if.hready); end
    step();
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_NONSEQ || s_if.hmaster !== 1'b0) begin errors++; $display("FAIL lock_c3_grant: got htrans %0h hmaster %0b expected 2/0", s_if.htrans, s_if.hmaster); end
    checks++; if (s_if.haddr !== 32'h500) begin errors++; $display("FAIL lock_c3_haddr: got %0h expected 500", s_if.haddr); end
    step();
    #2;
    checks++; if (m0_if.hready !== 1'b1) begin errors++; $display("FAIL lock_c4_m0_hready: got %0b expected 1", m0_if.hready); end
  endtask

  task automatic test_error();
    step();
    bus_idle();
    m1_drive(AHB_HTRANS_NONSEQ, 32'h600, 1'b0, 1'b0);
    #2;
    checks++; if (s_if.hmaster !== 1'b1) begin errors++; $display("FAIL err_c0_hmaster: got %0b expected 1", s_if.hmaster); end
    step();
    m1_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    m0_drive(AHB_HTRANS_NONSEQ, 32'h700, 1'b0, 1'b0);
    s_if.hready = 1'b0;
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL err_c1_htrans: got %0h expected 0", s_if.htrans); end
    checks++; if (m1_if.hready !== 1'b0) begin errors++; $display("FAIL err_c1_m1_hready: got %0b expected 0", m1_if.hready); end
    step();
    m0_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    #2;
    checks++; if ({m0_if.hready, m1_if.hready} !== 2'b00) begin errors++; $display("FAIL err_c2_hready: got %b expected 00", {m0_if.hready, m1_if.hready}); end
    step();
    s_if.hresp = AHB_HRESP_ERROR;
    #2;
    checks++; if ({m1_if.hresp, m1_if.hready} !== 2'b10) begin errors++; $display("FAIL err_c3_m1: got resp/ready %b expected 10", {m1_if.hresp, m1_if.hready}); end
    checks++; if (m0_if.hresp !== 1'b0) begin errors++; $display("FAIL err_c3_m0_hresp: got %0b expected 0", m0_if.hresp); end
    step();
    s_if.hready = 1'b1;
    #2;
    checks++; if ({m1_if.hresp, m1_if.hready} !== 2'b11) begin errors++; $display("FAIL err_c4_m1: got resp/ready %b expected 11", {m1_if.hresp, m1_if.hready}); end
    checks++; if (m0_if.hresp !== 1'b0) begin errors++; $display("FAIL err_c4_m0_hresp: got %0b expected 0", m0_if.hresp); end
    checks++; if (s_if.htrans !== AHB_HTRANS_NONSEQ || s_if.haddr !== 32'h700 || s_if.hmaster !== 1'b0) begin errors++; $display("FAIL err_c4_m0_issue: got htrans %0h haddr %0h hmaster %0b expected 2/700/0", s_if.htrans, s_if.haddr, s_if.hmaster); end
    step();
    s_if.hresp = AHB_HRESP_OKAY;
    #2;
    checks++; if (m0_if.hready !== 1'b1) begin errors++; $display("FAIL err_c5_m0_hready: got %0b expected 1", m0_if.hready); end
  endtask

  task automatic test_back_to_back();
    logic exp_m;
    step();
    rstn = 1'b0;
    bus_idle();
    step();
    rstn = 1'b1;
    s_if.hready = 1'b0;
    m0_drive(AHB_HTRANS_NONSEQ, 32'hA00, 1'b0, 1'b0);
    m1_drive(AHB_HTRANS_NONSEQ, 32'hB00, 1'b0, 1'b0);
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL b2b_noslot_htrans: got %0h expected 0", s_if.htrans); end
    for (int i = 0; i < 4; i++) begin
      step();
      s_if.hready = 1'b1;
      #2;
      exp_m = (i % 2 == 0) ? FIRST_TIE : !FIRST_TIE;
      checks++; if (s_if.hmaster !== exp_m || s_if.htrans !== AHB_HTRANS_NONSEQ) begin errors++; $display("FAIL b2b_grant%0d: got hmaster %0b htrans %0h expected %0b/2", i, s_if.hmaster, s_if.htrans, exp_m); end
      checks++; if (s_if.haddr !== (exp_m ? 32'hB00 : 32'hA00)) begin errors++; $display("FAIL b2b_addr%0d: got %0h expected %0h", i, s_if.haddr, exp_m ? 32'hB00 : 32'hA00); end
    end
    bus_idle();
    step(); step(); step();
  endtask

  task automatic test_reset_mid();
    int busy;
    step();
    m1_drive(AHB_HTRANS_NONSEQ, 32'hC00, 1'b1, 1'b0);
    m1_if.hwdata = 32'h11;
    #2;
    checks++; if (s_if.hmaster !== 1'b1) begin errors++; $display("FAIL rmid_c0_hmaster: got %0b expected 1", s_if.hmaster); end
    step();
    m1_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    m1_if.hwdata = 32'h22;
    m0_drive(AHB_HTRANS_NONSEQ, 32'h800, 1'b0, 1'b0);
    s_if.hready = 1'b0;
    #2;
    checks++; if (s_if.hwdata !== 32'h22) begin errors++; $display("FAIL rmid_c1_hwdata: got %0h expected 22", s_if.hwdata); end
    step();
    m0_drive(AHB_HTRANS_IDLE, 32'h0, 1'b0, 1'b0);
    #2;
    checks++; if ({m0_if.hready, m1_if.hready} !== 2'b00) begin errors++; $display("FAIL rmid_pre_hready: got %b expected 00", {m0_if.hready, m1_if.hready}); end
    rstn = 1'b0;
    #1;
    checks++; if ({m0_if.hready, m1_if.hready} !== 2'b11) begin errors++; $display("FAIL rmid_rst_hready: got %b expected 11", {m0_if.hready, m1_if.hready}); end
    checks++; if (s_if.hmaster !== 1'b0 || s_if.htrans !== AHB_HTRANS_IDLE) begin errors++; $display("FAIL rmid_rst_slave: got hmaster %0b htrans %0h expected 0/0", s_if.hmaster, s_if.htrans); end
    checks++; if (s_if.hwdata !== 32'h0) begin errors++; $display("FAIL rmid_rst_hwdata: got %0h expected 0", s_if.hwdata); end
    s_if.hready = 1'b1;
    step(); step();
    rstn = 1'b1;
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      if (s_if.htrans !== AHB_HTRANS_IDLE) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL rmid_no_ghost: got %0d busy cycles expected 0", busy); end
    step();
    m0_drive(AHB_HTRANS_NONSEQ, 32'h900, 1'b0, 1'b0);
    #2;
    checks++; if (s_if.htrans !== AHB_HTRANS_NONSEQ || s_if.haddr !== 32'h900) begin errors++; $display("FAIL rmid_new_req: got htrans %0h haddr %0h expected 2/900", s_if.htrans, s_if.haddr); end
    step();
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef CORE_AHB_ARB_RR_EN
    test_contention();
`endif
    test_lock();
    test_error();
    test_back_to_back();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
